// File: rtl/reg_bank_pkg.sv
// Shared definitions for the byte-stream register bank: FSM states,
// command-byte field positions and the register map used by the PWM stage.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RDATA = 2'd2
    } state_t;

    localparam int ADDR_W      = 4;
    localparam int NUM_REGS    = 16;
    localparam int STAGE_DEPTH = 8;
    localparam int SLOT_W      = 3;

    // Command byte layout: {write, count-1, start address}
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_CNT_MSB  = 6;
    localparam int CMD_CNT_LSB  = 4;
    localparam int CMD_ADDR_MSB = 3;
    localparam int CMD_ADDR_LSB = 0;

    // Register map shared with the IO/PWM output stage
    localparam logic [ADDR_W-1:0] REG_ID       = 4'd0;
    localparam logic [ADDR_W-1:0] REG_PWM1H    = 4'd5;
    localparam logic [ADDR_W-1:0] REG_PWM1T    = 4'd7;
    localparam logic [ADDR_W-1:0] REG_PWM1_DIV = 4'd8;
    localparam logic [ADDR_W-1:0] REG_PWM2H    = 4'd10;
    localparam logic [ADDR_W-1:0] REG_PWM2T    = 4'd12;
    localparam logic [ADDR_W-1:0] REG_PWM2_DIV = 4'd13;

    // Byte count carried by a command (1..8); the field holds count-1.
    function automatic logic [ADDR_W-1:0] cmd_count(input logic [7:0] cmd);
        return {1'b0, cmd[CMD_CNT_MSB:CMD_CNT_LSB]} + 4'd1;
    endfunction

    // Register address 'off' bytes after 'base'; wraps 15 -> 0 naturally.
    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/reg_bank_stage.sv
// Write stage buffer: collects the data bytes of one write burst and presents
// them as a per-register commit mask and data vector, so the live bank can
// take the whole burst on a single edge. The byte being accepted this cycle
// is merged into the view so the last byte commits together with the rest.
module reg_bank_stage
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = STAGE_DEPTH
) (
    input  logic                      clock,
    input  logic                      i_clear,
    input  logic                      i_wr_en,
    input  logic [SLOT_W-1:0]         i_wr_slot,
    input  logic [7:0]                i_wr_data,
    input  logic [ADDR_W-1:0]         i_base_addr,
    input  logic [ADDR_W-1:0]         i_count,
    output logic [NUM_REGS-1:1]       o_commit_mask,
    output logic [NUM_REGS*8-1:8]     o_commit_data
);

    logic [7:0]        r_slot [DEPTH];
    logic [7:0]        w_view [DEPTH];
    logic [ADDR_W-1:0] w_tgt;

    // Slot storage: cleared when a write command is accepted, one slot per data byte.
    // NOTE: the buffer has no reset on purpose -- every write burst clears it
    // before use and nothing reads a slot the current burst has not written.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
        end else if (i_wr_en) begin
            r_slot[i_wr_slot] <= i_wr_data;
        end
    end

    // Buffer view with the in-flight byte substituted into its slot.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_view[k] = (i_wr_en && (i_wr_slot == SLOT_W'(k))) ? i_wr_data : r_slot[k];
        end
    end

    // Map slots onto target registers; register 0 is read-only and never masked in.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a bit unassigned and no latch is inferred.
        o_commit_mask = '0;
        o_commit_data = '0;
        w_tgt         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_tgt = addr_add(i_base_addr, ADDR_W'(k));
            if ((ADDR_W'(k) < i_count) && (w_tgt != REG_ID)) begin
                o_commit_mask[w_tgt]               = 1'b1;
                o_commit_data[{w_tgt, 3'b000} +: 8] = w_view[k];
            end
        end
    end

endmodule

// File: rtl/reg_bank_rx.sv
// Byte-stream register bank: decodes host commands, stages write bursts and
// commits them atomically into 16 x 8-bit control registers, and returns
// burst reads over a byte-wide valid/ready channel.
module reg_bank_rx
    import reg_bank_pkg::*;
#(
    parameter logic [7:0] ID_VALUE  = 8'hA5,
    parameter int         NREGS     = NUM_REGS,
    parameter int         MAX_BURST = STAGE_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NREGS*8-1:0]   registers_packed,
    output logic                 commit,
    output logic                 busy
);

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_addr;      // start address (write) / read pointer (read)
    logic [ADDR_W-1:0] r_count;     // burst length (write) / bytes left (read)
    logic [SLOT_W-1:0] r_slot;      // next stage slot during a write burst
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_commit;
    logic [7:0]        r_regs [1:NREGS-1];

    logic              w_rx_ready;
    logic              w_cmd_accept;
    logic              w_wr_accept;
    logic              w_wr_last;
    logic              w_rd_last;
    logic              w_cmd_wr;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_cmd_cnt;
    logic [ADDR_W-1:0] w_rd_next;
    logic [NREGS*8-1:0] w_regs_packed;
    logic [NUM_REGS-1:1]   w_commit_mask;
    logic [NUM_REGS*8-1:8] w_commit_data;

    assign w_cmd_wr   = rx_data[CMD_WR_BIT];
    assign w_cmd_addr = rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_cmd_cnt  = cmd_count(rx_data);
    assign w_rd_next  = addr_add(r_addr, 4'd1);

    reg_bank_stage #(
        .DEPTH (MAX_BURST)
    ) u_stage (
        .clock         (clock),
        .i_clear       (w_cmd_accept && w_cmd_wr),
        .i_wr_en       (w_wr_accept),
        .i_wr_slot     (r_slot),
        .i_wr_data     (rx_data),
        .i_base_addr   (r_addr),
        .i_count       (r_count),
        .o_commit_mask (w_commit_mask),
        .o_commit_data (w_commit_data)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_rx_ready   = 1'b1;
        w_cmd_accept = 1'b0;
        w_wr_accept  = 1'b0;
        w_wr_last    = 1'b0;
        w_rd_last    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    w_cmd_accept = 1'b1;
                    w_state_next = w_cmd_wr ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    w_wr_accept = 1'b1;
                    if ({1'b0, r_slot} == (r_count - 4'd1)) begin
                        w_wr_last    = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            RDATA: begin
                w_rx_ready = 1'b0;
                if (r_tx_valid && tx_ready && (r_count == 4'd1)) begin
                    w_rd_last    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Burst bookkeeping, read-return byte and the commit pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_slot     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            r_commit <= w_wr_last;
            if (w_cmd_accept) begin
                r_addr  <= w_cmd_addr;
                r_count <= w_cmd_cnt;
                r_slot  <= '0;
                if (!w_cmd_wr) begin
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= w_regs_packed[{w_cmd_addr, 3'b000} +: 8];
                end
            end else if (w_wr_accept) begin
                r_slot <= r_slot + 3'd1;
            end else if ((r_state == RDATA) && r_tx_valid && tx_ready) begin
                if (w_rd_last) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_addr    <= w_rd_next;
                    r_count   <= r_count - 4'd1;
                    r_tx_data <= w_regs_packed[{w_rd_next, 3'b000} +: 8];
                end
            end
        end
    end

    // Live registers 1..15: every byte of a burst lands on the last-byte edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 1; r < NREGS; r++) begin
                r_regs[r] <= 8'h00;
            end
        end else if (w_wr_last) begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_commit_mask[r]) begin
                    r_regs[r] <= w_commit_data[8*r +: 8];
                end
            end
        end
    end

    // Packed view of the bank with the fixed ID in register 0.
    always_comb begin
        w_regs_packed       = '0;
        w_regs_packed[7:0]  = ID_VALUE;
        for (int r = 1; r < NREGS; r++) begin
            w_regs_packed[8*r +: 8] = r_regs[r];
        end
    end

    assign registers_packed = w_regs_packed;
    assign rx_ready         = w_rx_ready;
    assign tx_data          = r_tx_data;
    assign tx_valid         = r_tx_valid;
    assign commit           = r_commit;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_reg_bank_rx.sv
// Self-checking bench for reg_bank_rx: directed scenarios followed by random
// read/write bursts, all compared against a simple array model of the bank.
module tb_reg_bank_rx;

    localparam logic [7:0] ID = 8'hA5;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] registers_packed;
    logic         commit;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model [16];
    logic [7:0] wbuf  [8];

    always #5 clock = ~clock;

    reg_bank_rx #(
        .ID_VALUE  (ID),
        .NREGS     (16),
        .MAX_BURST (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .registers_packed (registers_packed),
        .commit           (commit),
        .busy             (busy)
    );

    function automatic logic [127:0] model_packed();
        logic [127:0] v;
        for (int r = 0; r < 16; r++) v[8*r +: 8] = model[r];
        return v;
    endfunction

    task automatic model_reset();
        model[0] = ID;
        for (int r = 1; r < 16; r++) model[r] = 8'h00;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one byte and hold it until the bank accepts it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 100) begin
            step();
            waited++;
        end
        if (!rx_ready) check("rx_accept_timeout", rx_ready, 1'b1);
        step();
        rx_valid = 1'b0;
    endtask

    // Data phase of a write burst whose command was already accepted.
    task automatic finish_write(input logic [3:0] addr, input int cnt);
        logic [3:0] a;
        for (int i = 0; i < cnt; i++) begin
            check("wr_busy", busy, 1'b1);
            if (i == cnt - 1) begin
                check("pre_commit_regs", registers_packed, model_packed());
                check("pre_commit_pulse", commit, 1'b0);
            end
            send_byte(wbuf[i]);
        end
        for (int i = 0; i < cnt; i++) begin
            a = addr + 4'(i);
            if (a != 4'd0) model[a] = wbuf[i];
        end
        check("commit_pulse", commit, 1'b1);
        check("commit_regs", registers_packed, model_packed());
        check("commit_idle", busy, 1'b0);
        step();
        check("commit_single", commit, 1'b0);
        check("post_commit_regs", registers_packed, model_packed());
    endtask

    task automatic do_write(input logic [3:0] addr, input int cnt);
        send_byte({1'b1, 3'(cnt - 1), addr});
        finish_write(addr, cnt);
    endtask

    task automatic do_read(input logic [3:0] addr, input int cnt, input int stall, input bit rnd);
        int         waited;
        int         hold;
        logic [3:0] a;
        hold = stall;
        send_byte({1'b0, 3'(cnt - 1), addr});
        for (int i = 0; i < cnt; i++) begin
            a      = addr + 4'(i);
            waited = 0;
            forever begin
                if (hold > 0) begin
                    tx_ready = 1'b0;
                    hold--;
                end else begin
                    tx_ready = (rnd && waited < 10) ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                check("rd_tx_valid", tx_valid, 1'b1);
                check("rd_tx_data", tx_data, model[a]);
                check("rd_rx_blocked", rx_ready, 1'b0);
                step();
                if (tx_ready) break;
                waited++;
            end
        end
        tx_ready = 1'b0;
        check("rd_end_tx_valid", tx_valid, 1'b0);
        check("rd_end_busy", busy, 1'b0);
        check("rd_end_rx_ready", rx_ready, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        model_reset();

        // Reset held two cycles.
        step();
        step();
        reset = 1'b0;
        check("rst_regs", registers_packed, {120'h0, ID});
        check("rst_busy", busy, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_commit", commit, 1'b0);
        step();

        // Write burst: cmd B4 -> regs 4..7.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        send_byte(8'hB4);
        finish_write(4'd4, 4);
        check("wr_reg7", registers_packed[63:56], 8'h44);

        // Wrap onto register 0: cmd 9F, AA to reg15, BB dropped.
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        send_byte(8'h9F);
        finish_write(4'd15, 2);
        check("wrap_reg15", registers_packed[127:120], 8'hAA);
        check("wrap_reg0", registers_packed[7:0], ID);

        // Read cmd 35 with 5 stalled cycles: 22,33,44,00.
        do_read(4'd5, 4, 5, 1'b0);

        // Reset in the middle of an 8-byte write.
        send_byte(8'hF1);
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            send_byte(wbuf[i]);
            check("midwr_no_commit", commit, 1'b0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check("midwr_rst_regs", registers_packed, model_packed());
        check("midwr_rst_busy", busy, 1'b0);
        check("midwr_rst_commit", commit, 1'b0);
        check("midwr_rst_rx_ready", rx_ready, 1'b1);
        check("midwr_rst_tx_valid", tx_valid, 1'b0);
        step();
        check("midwr_after_commit", commit, 1'b0);
        wbuf[0] = 8'h05; wbuf[1] = 8'h06;
        do_write(4'd1, 2);

        // New command presented while a read is still pending.
        send_byte(8'h11);
        rx_data  = 8'h81;
        rx_valid = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("blk_rx_ready", rx_ready, 1'b0);
            check("blk_tx_data0", tx_data, model[1]);
            step();
        end
        tx_ready = 1'b1;
        step();
        check("blk_tx_data1", tx_data, model[2]);
        check("blk_rx_ready_mid", rx_ready, 1'b0);
        step();
        check("blk_rx_ready_idle", rx_ready, 1'b1);
        check("blk_tx_done", tx_valid, 1'b0);
        tx_ready = 1'b0;
        step();
        rx_valid = 1'b0;
        check("blk_cmd_taken", busy, 1'b1);
        wbuf[0] = 8'h5C;
        finish_write(4'd1, 1);

        // Random bursts against the model.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] addr;
            int         cnt;
            addr = 4'($urandom_range(0, 15));
            cnt  = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                do_write(addr, cnt);
            end else begin
                do_read(addr, cnt, $urandom_range(0, 3), 1'b1);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
